// File: rtl/mem_arb_pkg.sv
// Shared types and bus-width constants for the memory bus arbiter.
// Optional fetch anti-starvation is enabled by defining MEM_ARB_FAIRNESS_EN.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_INSTR = 2'd1,
    BUSY_DATA  = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    MEM_OWNER_INSTR = 1'b0,
    MEM_OWNER_DATA  = 1'b1
  } mem_owner_t;

  function automatic mem_arb_state_t busy_state(input mem_owner_t owner);
    return (owner == MEM_OWNER_DATA) ? BUSY_DATA : BUSY_INSTR;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, load/store and memory-bus signals of the arbiter.
// slave: arbiter view; master: core/interconnect view.
interface mem_bus_arbiter_if;
  import mem_arb_pkg::*;

  logic                  instr_valid_in;
  logic [MEM_ADDR_W-1:0] instr_addr_in;
  logic                  instr_ready_out;
  logic [MEM_DATA_W-1:0] instr_rdata_out;

  logic                  data_valid_in;
  logic [MEM_ADDR_W-1:0] data_addr_in;
  logic                  data_write_in;
  logic [MEM_MASK_W-1:0] data_wmask_in;
  logic [MEM_DATA_W-1:0] data_wdata_in;
  logic                  data_ready_out;
  logic [MEM_DATA_W-1:0] data_rdata_out;

  logic                  mem_valid_out;
  logic [MEM_ADDR_W-1:0] mem_addr_out;
  logic                  mem_write_out;
  logic [MEM_MASK_W-1:0] mem_wmask_out;
  logic [MEM_DATA_W-1:0] mem_wdata_out;
  logic                  mem_ready_in;
  logic [MEM_DATA_W-1:0] mem_rdata_in;

  modport slave (
    input  instr_valid_in, instr_addr_in,
    output instr_ready_out, instr_rdata_out,
    input  data_valid_in, data_addr_in, data_write_in, data_wmask_in, data_wdata_in,
    output data_ready_out, data_rdata_out,
    output mem_valid_out, mem_addr_out, mem_write_out, mem_wmask_out, mem_wdata_out,
    input  mem_ready_in, mem_rdata_in
  );

  modport master (
    output instr_valid_in, instr_addr_in,
    input  instr_ready_out, instr_rdata_out,
    output data_valid_in, data_addr_in, data_write_in, data_wmask_in, data_wdata_in,
    input  data_ready_out, data_rdata_out,
    input  mem_valid_out, mem_addr_out, mem_write_out, mem_wmask_out, mem_wdata_out,
    output mem_ready_in, mem_rdata_in
  );

endinterface

// File: rtl/mem_arb_fairness.sv
// Data-streak counter: after MAX_DATA_BURST data grants with fetch waiting,
// the next contested arbitration goes to fetch. Used under MEM_ARB_FAIRNESS_EN.
module mem_arb_fairness #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic instr_valid_in,
  input  logic data_grant_in,
  input  logic instr_grant_in,
  output logic fetch_override_out
);

  logic [3:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (instr_grant_in)
      streak_d = '0;
    else if (data_grant_in && instr_valid_in)
      streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  assign fetch_override_out = (streak_q == 4'(MAX_DATA_BURST));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter (fetch vs. load/store), one outstanding
// transaction, data priority. Define MEM_ARB_FAIRNESS_EN for fetch anti-starvation.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input logic         clk,
  input logic         reset,
  mem_bus_arbiter_if.slave bus
);

  mem_arb_state_t        state_q, state_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_write_q, mem_write_d;
  logic [MEM_MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic [MEM_DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic grant_data, grant_instr, fetch_override;

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_fairness #(.MAX_DATA_BURST(MAX_DATA_BURST)) u_fairness (
    .clk               (clk),
    .reset             (reset),
    .instr_valid_in    (bus.instr_valid_in),
    .data_grant_in     (grant_data),
    .instr_grant_in    (grant_instr),
    .fetch_override_out(fetch_override)
  );
`else
  localparam int unsigned unused_max_data_burst = MAX_DATA_BURST;
  assign fetch_override = 1'b0;
`endif

  // Arbitration happens only in IDLE, so every transaction costs at least two cycles.
  always_comb begin
    grant_data  = 1'b0;
    grant_instr = 1'b0;
    if (state_q == IDLE) begin
      if (bus.data_valid_in && !(bus.instr_valid_in && fetch_override))
        grant_data = 1'b1;
      else if (bus.instr_valid_in)
        grant_instr = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_write_d = mem_write_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = busy_state(MEM_OWNER_DATA);
          mem_valid_d = 1'b1;
          mem_addr_d  = bus.data_addr_in;
          mem_write_d = bus.data_write_in;
          mem_wmask_d = bus.data_write_in ? bus.data_wmask_in : '0;
          mem_wdata_d = bus.data_wdata_in;
        end else if (grant_instr) begin
          state_d     = busy_state(MEM_OWNER_INSTR);
          mem_valid_d = 1'b1;
          mem_addr_d  = bus.instr_addr_in;
          mem_write_d = 1'b0;
          mem_wmask_d = '0;
          mem_wdata_d = '0;
        end
      end
      BUSY_INSTR, BUSY_DATA: begin
        if (bus.mem_ready_in) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // A transaction abandoned by reset must not complete toward the requester.
  assign bus.instr_ready_out = !reset && (state_q == BUSY_INSTR) && bus.mem_ready_in;
  assign bus.data_ready_out  = !reset && (state_q == BUSY_DATA)  && bus.mem_ready_in;
  assign bus.instr_rdata_out = bus.mem_rdata_in;
  assign bus.data_rdata_out  = bus.mem_rdata_in;

  assign bus.mem_valid_out = mem_valid_q;
  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.mem_write_out = mem_write_q;
  assign bus.mem_wmask_out = mem_wmask_q;
  assign bus.mem_wdata_out = mem_wdata_q;

endmodule
